mips_bus_mem_model: RTL and testbench

//  Parametrised word-addressed RAM slave for the mips_cpu_bus Avalon-style port; drives the CPU
//  in every bus-level testbench. Maps byte addresses from BASE_ADDR (reset vector) into a

---
 rtl/mips_bus_mem_model.sv | 87 ++++++++
 tb/tb_mips_bus_mem_model.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_bus_mem_model.sv
// mips_bus_mem_model: word-addressed RAM slave with waitrequest stalls, access checking and debug peek
module mips_bus_mem_model #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int DEPTH = 64,
  parameter int LATENCY = 0,
  parameter bit RAND_STALL = 1'b0,
  parameter string INIT_FILE = "",
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          write,
  input  logic          read,
  output logic          waitrequest,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic [31:0]   readdata,
  output logic          err,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count,
  input  logic [IW-1:0] dbg_idx,
  output logic [31:0]   dbg_data
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [29:0] widx;
  logic [4:0] cnt, cnt_n, stall;
  logic [7:0] lfsr;
  logic req, zero_rd, legal, commit, drop;
  assign req = read || write;
  assign widx = 30'((address - BASE_ADDR) >> 2);
  assign zero_rd = read && !write && address == 32'h0;
  assign legal = zero_rd || (address[1:0] == 2'b00 && widx < 30'(DEPTH) && !(read && write));
  assign stall = 5'(LATENCY) + (RAND_STALL ? {3'b000, lfsr[1:0]} : 5'd0);
  assign dbg_data = mem[dbg_idx];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    waitrequest = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        if (req && stall == 5'd0) commit = 1'b1;
        else if (req) begin
          waitrequest = 1'b1;
          cnt_n = stall - 5'd1;
          state_n = WAIT;
        end
      end else if (!req) begin
        drop = 1'b1;
        state_n = IDLE;
      end else if (cnt != 5'd0) begin
        waitrequest = 1'b1;
        cnt_n = cnt - 5'd1;
      end else begin
        commit = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 5'd0;
      readdata <= 32'h0;
      err <= 1'b0;
      rd_count <= 16'h0;
      wr_count <= 16'h0;
      lfsr <= 8'hA5;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err <= drop || (commit && !legal);
      if (commit) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (commit && read) readdata <= (legal && !zero_rd) ? mem[widx[IW-1:0]] : 32'h0;
      if (commit && legal && read) rd_count <= rd_count + 16'd1;
      if (commit && legal && write) wr_count <= wr_count + 16'd1;
    end
  end
  always_ff @(posedge clk)
    if (commit && legal && write)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[widx[IW-1:0]][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_mips_bus_mem_model.sv
// tb_mips_bus_mem_model: three memory instances (no stall, fixed 3, random 1..4) against an array model
module tb_mips_bus_mem_model;
  localparam logic [31:0] BASE = 32'hBFC00000;
  logic clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
  logic [31:0] address = 32'h0, writedata = 32'h0;
  logic [3:0] byteenable = 4'h0;
  logic [5:0] dbg_idx = 6'd0;
  int sel = 0;
  logic [2:0] wreq, errv;
  logic [31:0] rdata [3];
  logic [31:0] dbg [3];
  logic [15:0] rc [3];
  logic [15:0] wc [3];
  logic [31:0] mm [3][64];
  logic [31:0] last [3];
  logic [15:0] erc [3];
  logic [15:0] ewc [3];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_bus_mem_model #(
      .BASE_ADDR(BASE), .DEPTH(64), .LATENCY(g == 1 ? 3 : g == 2 ? 1 : 0),
      .RAND_STALL(g == 2), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(reset), .address(address),
      .write(write && sel == g), .read(read && sel == g),
      .waitrequest(wreq[g]), .writedata(writedata), .byteenable(byteenable),
      .readdata(rdata[g]), .err(errv[g]), .rd_count(rc[g]), .wr_count(wc[g]),
      .dbg_idx(dbg_idx), .dbg_data(dbg[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic acc(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, output int st);
    bit done = 1'b0;
    sel = k; address = a; read = r; write = w; writedata = d; byteenable = be; st = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wreq[k]) begin
        st++;
        @(posedge clk);
        #1;
      end else done = 1'b1;
    end
    if (!done) chk("handshake_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask
  task automatic op(input int k, input logic r, input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    int st;
    logic [31:0] idx;
    bit lg;
    acc(k, r, w, a, d, be, st);
    idx = (a - BASE) >> 2;
    lg = (r && !w && a == 32'h0) || (a[1:0] == 2'b00 && idx < 64 && !(r && w));
    if (lg && w)
      for (int i = 0; i < 4; i++) if (be[i]) mm[k][idx[5:0]][8*i +: 8] = d[8*i +: 8];
    if (r) last[k] = (lg && a != 32'h0) ? mm[k][idx[5:0]] : 32'h0;
    if (lg && r) erc[k]++;
    if (lg && w) ewc[k]++;
    if (k == 2) chk("stall_range", 32'(st >= 1 && st <= 4), 32'd1);
    else chk("stall", st, k == 1 ? 32'd3 : 32'd0);
    chk("readdata", rdata[k], last[k]);
    chk("err", 32'(errv[k]), 32'(!lg));
    chk("rd_count", 32'(rc[k]), 32'(erc[k]));
    chk("wr_count", 32'(wc[k]), 32'(ewc[k]));
  endtask
  initial begin
    logic [31:0] a;
    int u;
    bit r, w;
    for (int k = 0; k < 3; k++) begin
      last[k] = 32'h0; erc[k] = 16'h0; ewc[k] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_waitrequest", 32'(wreq[k]), 32'd0);
      chk("rst_readdata", rdata[k], 32'h0);
      chk("rst_err", 32'(errv[k]), 32'd0);
      chk("rst_rd_count", 32'(rc[k]), 32'd0);
      chk("rst_wr_count", 32'(wc[k]), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) op(k, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
    op(0, 1'b0, 1'b1, BASE + 32'h30, 32'h000000F3, 4'hF);
    op(0, 1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'h0);
    chk("lat0_read_F3", rdata[0], 32'h000000F3);
    dbg_idx = 6'd12;
    #1;
    chk("dbg_idx12", dbg[0], 32'h000000F3);
    op(0, 1'b0, 1'b1, BASE + 32'h10, 32'h11223344, 4'hF);
    op(0, 1'b0, 1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'b0101);
    dbg_idx = 6'd4;
    #1;
    chk("lane_mask", dbg[0], 32'h11BB33DD);
    op(0, 1'b0, 1'b1, BASE + 32'h14, 32'hCAFEF00D, 4'h0);
    op(1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
    op(1, 1'b1, 1'b0, BASE + 32'h2, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(errv[1]), 32'd0);
    op(1, 1'b0, 1'b1, BASE + 32'd256, 32'hDEADBEEF, 4'hF);
    op(1, 1'b1, 1'b1, BASE + 32'hC, 32'h12345678, 4'hF);
    dbg_idx = 6'd3;
    #1;
    chk("collision_mem", dbg[1], mm[1][3]);
    op(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("addr0_readdata", rdata[1], 32'h0);
    sel = 1; address = BASE + 32'h14; read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_err", 32'(errv[1]), 32'd1);
    chk("drop_readdata", rdata[1], last[1]);
    chk("drop_rd_count", 32'(rc[1]), 32'(erc[1]));
    @(posedge clk);
    #1;
    chk("drop_err_clear", 32'(errv[1]), 32'd0);
    dbg_idx = 6'd7;
    sel = 1; address = BASE + 32'h1C; write = 1'b1; writedata = ~mm[1][7]; byteenable = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_wait_wreq", 32'(wreq[1]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0;
    chk("rst_next_wreq", 32'(wreq[1]), 32'd0);
    chk("rst_mem_kept", dbg[1], mm[1][7]);
    chk("rst_wr_count", 32'(wc[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      last[k] = 32'h0; erc[k] = 16'h0; ewc[k] = 16'h0;
    end
    repeat (100) op(2, 1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, 63)), 32'h0, 4'h0);
    chk("rand_rd_count_100", 32'(rc[2]), 32'd100);
    for (int k = 0; k < 2; k++)
      repeat (60) begin
        u = $urandom_range(0, 9);
        r = 1'($urandom_range(0, 1));
        w = !r || $urandom_range(0, 15) == 0;
        a = u < 7 ? BASE + 32'(4 * $urandom_range(0, 63)) :
            u == 7 ? BASE + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3)) :
            u == 8 ? BASE + 32'd256 + 32'(4 * $urandom_range(0, 1000)) : 32'h0;
        op(k, r, w, a, $urandom, 4'($urandom));
      end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) begin
        dbg_idx = 6'(i);
        #1;
        chk("dbg_sweep", dbg[k], mm[k][i]);
      end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
